// File: rtl/tx_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tx_arbiter                                                                 |
// | Round-robin scheduler sharing one serial byte sender among NUM_REQ         |
// | requesters. Optional SEND watchdog enabled by defining TX_TIMEOUT_EN.      |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tx_arbiter #(
    parameter int NUM_REQ        = 4,
    parameter int ID_W           = 2,
    parameter int PARK_CYCLES    = 3,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NUM_REQ-1:0]   req,
    input  logic [8*NUM_REQ-1:0] req_data,
    output logic [NUM_REQ-1:0]   ack,
    output logic                 tx_err,
    output logic [7:0]           tx_data,
    output logic                 tx_en,
    input  logic                 tx_status,
    output logic                 busy,
    output logic [ID_W-1:0]      grant_id
);

    localparam int              c_PARK_W  = $clog2(PARK_CYCLES);
    localparam logic [ID_W:0]   c_NUM_REQ = (ID_W+1)'(NUM_REQ);
    localparam logic [ID_W-1:0] c_LAST_ID = ID_W'(NUM_REQ-1);

    if (ID_W != $clog2(NUM_REQ) || NUM_REQ < 2 || NUM_REQ > 8 ||
        PARK_CYCLES < 2 || TIMEOUT_CYCLES < 1) begin : g_param_check
        $error("tx_arbiter: illegal parameter set");
    end

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_LOAD = 3'd1,
        S_SEND = 3'd2,
        S_DONE = 3'd3,
        S_PARK = 3'd4
    } state_t;

    state_t                r_state, w_state_nx;
    logic [ID_W-1:0]       r_rr, w_rr_nx;
    logic [c_PARK_W-1:0]   r_park, w_park_nx;
    logic [ID_W-1:0]       w_grant_nx;
    logic [7:0]            w_data_nx;
    logic [NUM_REQ-1:0]    w_ack_nx;
    logic                  w_en_nx;
    logic                  w_busy_nx;
    logic                  w_any;
    logic [ID_W-1:0]       w_pick;
    logic [7:0]            w_pick_data;
    logic [ID_W:0]         w_idx;

`ifdef TX_TIMEOUT_EN
    localparam int              c_TO_W    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [c_TO_W-1:0] c_TO_LAST = c_TO_W'(TIMEOUT_CYCLES - 1);
    logic [c_TO_W-1:0]     r_to, w_to_nx;
    logic                  w_err_nx;
`endif

    // Scan downward so the lowest offset from the rr pointer wins.
    always_comb begin
        w_any       = 1'b0;
        w_pick      = '0;
        w_idx       = '0;
        w_pick_data = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            w_idx = {1'b0, r_rr} + (ID_W+1)'(k);
            if (w_idx >= c_NUM_REQ) w_idx = w_idx - c_NUM_REQ;
            if (req[w_idx[ID_W-1:0]]) begin
                w_any  = 1'b1;
                w_pick = w_idx[ID_W-1:0];
            end
        end
        for (int i = 0; i < NUM_REQ; i++) begin
            if (w_pick == ID_W'(i)) w_pick_data = req_data[8*i +: 8];
        end
    end

    always_comb begin
        w_state_nx = r_state;
        w_rr_nx    = r_rr;
        w_park_nx  = r_park;
        w_grant_nx = grant_id;
        w_data_nx  = tx_data;
        w_ack_nx   = '0;
`ifdef TX_TIMEOUT_EN
        w_to_nx    = r_to;
        w_err_nx   = 1'b0;
`endif
        case (r_state)
            // A status still high from the previous frame must not start a new one.
            S_IDLE: begin
                if (w_any && !tx_status) begin
                    w_state_nx = S_LOAD;
                    w_grant_nx = w_pick;
                    w_data_nx  = w_pick_data;
                end
            end
            S_LOAD: begin
                w_state_nx = S_SEND;
`ifdef TX_TIMEOUT_EN
                w_to_nx    = '0;
`endif
            end
            S_SEND: begin
                if (tx_status) begin
                    w_state_nx = S_DONE;
                    w_ack_nx[grant_id] = 1'b1;
                end
`ifdef TX_TIMEOUT_EN
                else if (r_to == c_TO_LAST) begin
                    w_state_nx = S_DONE;
                    w_ack_nx[grant_id] = 1'b1;
                    w_err_nx   = 1'b1;
                end else begin
                    w_to_nx = r_to + c_TO_W'(1);
                end
`endif
            end
            S_DONE: begin
                w_state_nx = S_PARK;
                w_park_nx  = c_PARK_W'(PARK_CYCLES - 1);
                w_rr_nx    = (grant_id == c_LAST_ID) ? '0 : grant_id + ID_W'(1);
            end
            S_PARK: begin
                if (r_park == '0) w_state_nx = S_IDLE;
                else              w_park_nx  = r_park - c_PARK_W'(1);
            end
            default: w_state_nx = S_IDLE;
        endcase
        w_en_nx   = (w_state_nx != S_SEND);
        w_busy_nx = (w_state_nx != S_IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= S_IDLE;
            r_rr     <= '0;
            r_park   <= '0;
            grant_id <= '0;
            tx_data  <= '0;
            tx_en    <= 1'b1;
            ack      <= '0;
            busy     <= 1'b0;
        end else begin
            r_state  <= w_state_nx;
            r_rr     <= w_rr_nx;
            r_park   <= w_park_nx;
            grant_id <= w_grant_nx;
            tx_data  <= w_data_nx;
            tx_en    <= w_en_nx;
            ack      <= w_ack_nx;
            busy     <= w_busy_nx;
        end
    end

`ifdef TX_TIMEOUT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_to   <= '0;
            tx_err <= 1'b0;
        end else begin
            r_to   <= w_to_nx;
            tx_err <= w_err_nx;
        end
    end
`else
    assign tx_err = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_tx_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_tx_arbiter                                                              |
// | Directed bench for tx_arbiter with a simple sender model.                  |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_tx_arbiter;

    localparam int FRAME_CLKS = 12;   // three send_clk periods at clk/4

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  req;
    logic [31:0] req_data;
    logic [3:0]  ack;
    logic        tx_err;
    logic [7:0]  tx_data;
    logic        tx_en;
    logic        tx_status;
    logic        busy;
    logic [1:0]  grant_id;

    int   stat_mode = 0;              // 0 = sender model, 1 = stuck high, 2 = stuck low
    logic model_st  = 1'b0;
    int   model_cnt = 0;
    int   n_cmp = 0;
    int   n_bad = 0;

    typedef struct {
        logic [3:0]  mask;
        logic [31:0] dw;
        logic [1:0]  g;
        logic [7:0]  d;
        bit          idle;
        int          lat;
    } vec_t;
    vec_t tbl [10];

    tx_arbiter #(
        .NUM_REQ        (4),
        .ID_W           (2),
        .PARK_CYCLES    (3),
        .TIMEOUT_CYCLES (64)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .req_data  (req_data),
        .ack       (ack),
        .tx_err    (tx_err),
        .tx_data   (tx_data),
        .tx_en     (tx_en),
        .tx_status (tx_status),
        .busy      (busy),
        .grant_id  (grant_id)
    );

    always #5 clk = ~clk;

    assign tx_status = (stat_mode == 0) ? model_st : (stat_mode == 1);

    always @(posedge clk) begin
        if (tx_en) begin
            model_cnt <= 0;
            model_st  <= 1'b0;
        end else if (model_cnt == FRAME_CLKS - 1) begin
            model_st  <= 1'b1;
        end else begin
            model_cnt <= model_cnt + 1;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic bound_fail(input string name);
        n_cmp++;
        n_bad++;
        $display("FAIL %s: wait bound expired, got no event, expected one", name);
    endtask

    task automatic idle_wait(input int cycles);
        req = '0;
        repeat (cycles) @(negedge clk);
        check("idle_busy", busy, 1'b0);
    endtask

    // Drives one frame and returns at the negedge after the ack cycle.
    task automatic run_frame(input logic [3:0] mask, input logic [31:0] dw,
                             input logic [1:0] g, input logic [7:0] d, input int lat);
        int n;
        bit ok;
        req_data = dw;
        req      = mask;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (tx_en !== 1'b0 && n < 100);
        if (tx_en !== 1'b0) begin
            bound_fail("wait_send");
            return;
        end
        check("latency", n, lat);
        check("grant_id", grant_id, g);
        check("tx_data", tx_data, d);
        ok = 1'b1;
        n  = 0;
        while (tx_status !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
            if (tx_data !== d || ack !== 4'b0 || (tx_status !== 1'b1 && tx_en !== 1'b0)) ok = 1'b0;
        end
        check("send_hold", ok, 1'b1);
        if (tx_status !== 1'b1) begin
            bound_fail("wait_status");
            return;
        end
        @(negedge clk);
        check("ack", ack, 4'b0001 << g);
        check("ack_tx_err", tx_err, 1'b0);
        check("ack_tx_en", tx_en, 1'b1);
        req = mask & ~(4'b0001 << g);
        @(negedge clk);
        check("ack_pulse", ack, 4'b0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int  n;
        bit  ok;
        rst_n    = 1'b0;
        req      = '0;
        req_data = '0;

        tbl[0] = '{4'b0100, 32'h44A52211, 2'd2, 8'hA5, 1'b1, 2};
        tbl[1] = '{4'b0001, 32'h13121110, 2'd0, 8'h10, 1'b0, 5};
        tbl[2] = '{4'b1001, 32'h13121110, 2'd3, 8'h13, 1'b1, 2};
        tbl[3] = '{4'b1001, 32'h13121110, 2'd0, 8'h10, 1'b0, 5};
        tbl[4] = '{4'b1000, 32'h13121110, 2'd3, 8'h13, 1'b0, 5};
        tbl[5] = '{4'b1111, 32'h13121110, 2'd0, 8'h10, 1'b0, 5};
        tbl[6] = '{4'b1111, 32'h13121110, 2'd1, 8'h11, 1'b0, 5};
        tbl[7] = '{4'b1111, 32'h13121110, 2'd2, 8'h12, 1'b0, 5};
        tbl[8] = '{4'b1111, 32'h13121110, 2'd3, 8'h13, 1'b0, 5};
        tbl[9] = '{4'b1111, 32'h13121110, 2'd0, 8'h10, 1'b0, 5};

        repeat (3) @(negedge clk);
        check("rst_tx_en", tx_en, 1'b1);
        check("rst_tx_data", tx_data, 8'h00);
        check("rst_ack", ack, 4'b0);
        check("rst_tx_err", tx_err, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_grant_id", grant_id, 2'd0);
        rst_n = 1'b1;

        for (int i = 0; i < 10; i++) begin
            if (tbl[i].idle) idle_wait(10);
            run_frame(tbl[i].mask, tbl[i].dw, tbl[i].g, tbl[i].d, tbl[i].lat);
        end
        req = '0;

        // Stale status at idle must hold off arbitration.
        idle_wait(10);
        stat_mode = 1;
        req_data  = 32'h13121110;
        req       = 4'b0010;
        ok = 1'b1;
        repeat (8) begin
            @(negedge clk);
            if (busy !== 1'b0 || tx_en !== 1'b1) ok = 1'b0;
        end
        check("stuck_no_grant", ok, 1'b1);
        check("stuck_grant_id", grant_id, 2'd0);
        stat_mode = 0;
        run_frame(4'b0010, 32'h13121110, 2'd1, 8'h11, 2);

        // Asynchronous reset in the middle of SEND.
        idle_wait(10);
        req = 4'b0100;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (tx_en !== 1'b0 && n < 100);
        if (tx_en !== 1'b0) bound_fail("rst_wait_send");
        check("rst_pre_grant", grant_id, 2'd2);
        repeat (3) @(negedge clk);
        #2;
        rst_n = 1'b0;
        req   = '0;
        #1;
        check("arst_tx_en", tx_en, 1'b1);
        check("arst_busy", busy, 1'b0);
        check("arst_grant_id", grant_id, 2'd0);
        check("arst_tx_data", tx_data, 8'h00);
        ok = 1'b1;
        repeat (3) begin
            @(negedge clk);
            if (ack !== 4'b0 || tx_en !== 1'b1) ok = 1'b0;
        end
        check("arst_no_ack", ok, 1'b1);
        rst_n = 1'b1;
        run_frame(4'b0001, 32'h13121110, 2'd0, 8'h10, 2);

`ifdef TX_TIMEOUT_EN
        // Sender never completes: watchdog aborts after 64 SEND cycles.
        stat_mode = 2;
        req_data  = 32'h13121110;
        req       = 4'b1001;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (tx_en !== 1'b0 && n < 100);
        if (tx_en !== 1'b0) bound_fail("to_wait_send");
        check("to_grant_id", grant_id, 2'd3);
        n = 1;
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            if (ack !== 4'b0) break;
            if (tx_en === 1'b0) n++;
        end
        check("to_send_cycles", n, 64);
        check("to_ack", ack, 4'b1000);
        check("to_tx_err", tx_err, 1'b1);
        req = 4'b0001;
        @(negedge clk);
        check("to_err_pulse", tx_err, 1'b0);
        check("to_ack_pulse", ack, 4'b0);
        stat_mode = 0;
        run_frame(4'b0001, 32'h13121110, 2'd0, 8'h10, 5);
`endif

        req = '0;
        repeat (10) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/tx_arbiter.md
Name: tx_arbiter

Overview:
- Round-robin scheduler sharing one serial sender (8-bit data, tx_en, tx_status) among NUM_REQ byte requesters.
- Selects a requester, presents its byte on tx_data and sequences tx_en. Monitors tx_status until the frame completes, then returns a one-cycle ack.
- Sits between the client logic and the sender. Sender timing (send_clk) is opaque; only tx_status is trusted.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- ID_W, 2, width of grant_id; must equal clog2(NUM_REQ).
- PARK_CYCLES, 3, clk cycles tx_en is held high after a frame before the next grant (min 2).
- TIMEOUT_CYCLES, 4096, clk cycles allowed in SEND before abort (used only with TX_TIMEOUT_EN).

Ports:
- clk  in  1  system clock; all logic on posedge.
- rst_n  in  1  asynchronous active-low reset.
- req  in  NUM_REQ  level request per requester; held until its ack.
- req_data  in  8*NUM_REQ  byte for requester i at [8*i+7:8*i]; stable while req[i]=1.
- ack  out  NUM_REQ  one-cycle completion pulse for the granted requester.
- tx_err  out  1  one-cycle pulse coincident with ack on aborted frame; constant 0 without TX_TIMEOUT_EN.
- tx_data  out  8  byte to sender; registered.
- tx_en  out  1  sender hold: 1 = sender parked in reset, 0 = sender runs.
- tx_status  in  1  from sender: 0 = parked or sending, 1 = frame complete.
- busy  out  1  1 in any state except IDLE.
- grant_id  out  ID_W  index of the current or last granted requester.

Behaviour:
- Reset values: tx_en=1, tx_data=0, ack=0, tx_err=0, busy=0, grant_id=0, state=IDLE, rr pointer=0. Reset takes effect at any time, including mid-frame; tx_en returns to 1 immediately and the frame is abandoned with no ack.
- Register all outputs. No combinational path from req to ack or tx_en.
- IDLE:
  - tx_en=1.
  - If any req=1 and tx_status=0, pick the first set req scanning upward from the rr pointer, wrapping at NUM_REQ.
  - Register grant_id and tx_data=req_data[grant], then go to LOAD.
  - If tx_status=1, stay in IDLE; a stale status is never treated as completion.
- LOAD: one cycle with tx_en=1 so tx_data is stable before the sender runs; then go to SEND.
- SEND: tx_en=0; tx_data held. When tx_status=1, go to DONE.
- DONE:
  - One cycle: ack[grant_id]=1, tx_en=1.
  - rr pointer = grant_id+1, wrapping NUM_REQ-1 to 0.
  - Then go to PARK.
- PARK:
  - tx_en=1 for PARK_CYCLES cycles, counted by a down-counter.
  - Then go to IDLE. IDLE's tx_status=0 check guards against a slow status deassertion.
- Latency: grant in IDLE -> tx_en falls 2 cycles later. tx_status=1 -> ack 1 cycle later.
- Fairness: after requester i is served, i has lowest priority. With all req=1, grant order is 0,1,2,3,0...
- req deasserted after grant: the frame still completes and ack still pulses; the requester must ignore it.
- A new req arriving during SEND/DONE/PARK is arbitrated in the next IDLE.
- ack[i] is also asserted for a requester whose req is held, so it can drop req the cycle after ack.

Optional Feature:
- Macro: TX_TIMEOUT_EN.
- Defined:
  - A cycle counter clears on entry to SEND.
  - If it reaches TIMEOUT_CYCLES with tx_status=0, go to DONE and assert ack[grant_id] and tx_err together for one cycle. rr pointer advances as normal.
  - A tx_status=1 on the same cycle the timeout expires counts as success (tx_err=0).
- Undefined: no counter, SEND waits indefinitely, tx_err tied 0.

Test Plan:
- Single request: sender model with send_clk=clk/4; req[2]=1, data 0xA5 -> tx_en falls 2 cycles after grant, tx_data=0xA5 through SEND, ack[2] one cycle after tx_status rises, grant_id=2.
- All four requesting continuously (bytes 0x10..0x13) -> bytes sent 0x10,0x11,0x12,0x13,0x10; each ack exactly one cycle; at least PARK_CYCLES cycles of tx_en=1 between frames.
- req[3] and req[0] set with rr pointer=1 -> grant 3 first, then 0.
- Stuck tx_status=1 at idle with req[1]=1 -> no grant and busy=0 until tx_status returns to 0.
- rst_n pulsed low mid-SEND -> tx_en=1 asynchronously, no ack, grant_id=0; a subsequent req[0] is served normally.
- TX_TIMEOUT_EN with TIMEOUT_CYCLES=64 and tx_status held 0 -> ack[g] and tx_err pulse after 64 SEND cycles; next requester served afterwards.
